// File: rtl/apb_ucpd_data_rx.sv
// UCPD receive data path.
// Hunts the decoded bit stream for an enabled ordered set. A match needs
// at least 3 of its 4 K-codes. After an SOP-class set the block decodes
// 5b symbols into nibbles and assembles bytes into RXDR. It counts the
// payload and checks the CRC-32 residue when EOP arrives.
//
// Receive-bit handshake: rx_bit is sampled only in a cycle where
// rx_bit_vld is high. There is no back-pressure, so every strobe is
// consumed in the cycle it arrives. rxdr_rd is a one-cycle pulse that
// consumes the byte held in rx_rxdr.

`ifndef SYNC_1
`define SYNC_1 5'b11000
`endif
`ifndef SYNC_2
`define SYNC_2 5'b10001
`endif
`ifndef SYNC_3
`define SYNC_3 5'b00110
`endif
`ifndef RST_1
`define RST_1 5'b00111
`endif
`ifndef RST_2
`define RST_2 5'b11001
`endif
`ifndef EOP
`define EOP 5'b01101
`endif

module apb_ucpd_data_rx #(
  parameter int PAYSZ_W = 10
) (
  input  logic               ic_clk,
  input  logic               ic_rst_n,
  input  logic               rx_en,
  input  logic               rx_bit,
  input  logic               rx_bit_vld,
  input  logic [6:0]         rx_ordset_en,
  input  logic               rxdr_rd,
  output logic [7:0]         rx_rxdr,
  output logic               rx_ne,
  output logic [2:0]         rx_ordset_type,
  output logic [PAYSZ_W-1:0] rx_paysz,
  output logic               rx_sop_det,
  output logic               rx_hrst_det,
  output logic               rx_crst_det,
  output logic               rx_ovr,
  output logic               rx_msg_end,
  output logic               rx_err,
  output logic               rx_busy
);

  localparam logic [4:0]  SYM_S1  = `SYNC_1;
  localparam logic [4:0]  SYM_S2  = `SYNC_2;
  localparam logic [4:0]  SYM_S3  = `SYNC_3;
  localparam logic [4:0]  SYM_R1  = `RST_1;
  localparam logic [4:0]  SYM_R2  = `RST_2;
  localparam logic [4:0]  SYM_EOP = `EOP;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [PAYSZ_W-1:0] PAYSZ_MAX = {PAYSZ_W{1'b1}};

  typedef enum logic [0:0] {ST_IDLE, ST_DATA} state_t;

  state_t       state, state_nxt;
  logic [19:0]  window;
  logic [19:0]  window_nxt;
  logic [4:0]   sym_sh;
  logic [4:0]   sym_nxt;
  logic [2:0]   bit_cnt;
  logic         nib_odd;
  logic [3:0]   low_nib;
  logic [31:0]  crc;
  logic         hit;
  logic [2:0]   hit_idx;
  logic [4:0]   dec;
  logic         dec_valid;
  logic [3:0]   dec_nib;
  logic [7:0]   new_byte;
  logic         sop_go;
  logic         hrst_go;
  logic         crst_go;
  logic         byte_done;
  logic         msg_end_go;
  logic         err_go;

  // Ordered-set table. Bits [4:0] hold the first symbol on the wire.
  function automatic logic [19:0] os_code(input int idx);
    logic [19:0] c;
    case (idx)
      0:       c = {SYM_S2, SYM_S1, SYM_S1, SYM_S1};
      1:       c = {SYM_S3, SYM_S3, SYM_S1, SYM_S1};
      2:       c = {SYM_S3, SYM_S1, SYM_S3, SYM_S1};
      3:       c = {SYM_R2, SYM_R1, SYM_R1, SYM_R1};
      4:       c = {SYM_S3, SYM_R1, SYM_S1, SYM_R1};
      5:       c = {SYM_S3, SYM_R2, SYM_R2, SYM_S1};
      default: c = {SYM_S2, SYM_S3, SYM_R2, SYM_S1};
    endcase
    return c;
  endfunction

  // A set matches when at least 3 of its 4 symbols are equal.
  function automatic logic set_match(input logic [19:0] w, input logic [19:0] s);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (w[i*5 +: 5] == s[i*5 +: 5]) n = n + 1;
    end
    return (n >= 3);
  endfunction

  // Inverse 4b5b table. Bit 4 flags a valid data symbol.
  function automatic logic [4:0] dec5b4b(input logic [4:0] s);
    logic [4:0] r;
    case (s)
      5'b11110: r = {1'b1, 4'h0};
      5'b01001: r = {1'b1, 4'h1};
      5'b10100: r = {1'b1, 4'h2};
      5'b10101: r = {1'b1, 4'h3};
      5'b01010: r = {1'b1, 4'h4};
      5'b01011: r = {1'b1, 4'h5};
      5'b01110: r = {1'b1, 4'h6};
      5'b01111: r = {1'b1, 4'h7};
      5'b10010: r = {1'b1, 4'h8};
      5'b10011: r = {1'b1, 4'h9};
      5'b10110: r = {1'b1, 4'hA};
      5'b10111: r = {1'b1, 4'hB};
      5'b11010: r = {1'b1, 4'hC};
      5'b11011: r = {1'b1, 4'hD};
      5'b11100: r = {1'b1, 4'hE};
      5'b11101: r = {1'b1, 4'hF};
      default:  r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // Reflected CRC-32 over one byte, processed LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d[i];
      c  = c >> 1;
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction

  assign window_nxt = {rx_bit, window[19:1]};
  assign sym_nxt    = {rx_bit, sym_sh[4:1]};
  assign dec        = dec5b4b(sym_nxt);
  assign dec_valid  = dec[4];
  assign dec_nib    = dec[3:0];
  assign new_byte   = {dec_nib, low_nib};
  assign rx_busy    = (state == ST_DATA);

  // Ordered-set search on the incoming window. Scanning downwards lets the
  // lowest enabled index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    for (int k = 6; k >= 0; k--) begin
      if (rx_ordset_en[k] && set_match(window_nxt, os_code(k))) begin
        hit     = 1'b1;
        hit_idx = 3'(k);
      end
    end
  end

  // Next-state and event decode.
  always_comb begin
    state_nxt  = state;
    sop_go     = 1'b0;
    hrst_go    = 1'b0;
    crst_go    = 1'b0;
    byte_done  = 1'b0;
    msg_end_go = 1'b0;
    err_go     = 1'b0;
    if (!rx_en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_bit_vld && hit) begin
            if (hit_idx == 3'd3) begin
              hrst_go = 1'b1;
            end else if (hit_idx == 3'd4) begin
              crst_go = 1'b1;
            end else begin
              sop_go    = 1'b1;
              state_nxt = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (rx_bit_vld && (bit_cnt == 3'd4)) begin
            if (dec_valid) begin
              byte_done = nib_odd;
            end else if (sym_nxt == SYM_EOP) begin
              msg_end_go = 1'b1;
              err_go     = nib_odd || (crc != CRC_RESIDUE);
              state_nxt  = ST_IDLE;
            end else begin
              msg_end_go = 1'b1;
              err_go     = 1'b1;
              state_nxt  = ST_IDLE;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Hunt window. It shifts only in IDLE and is cleared on a match or when disabled.
  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      window <= 20'd0;
    end else if (!rx_en || (state == ST_DATA)) begin
      window <= 20'd0;
    end else if (rx_bit_vld) begin
      window <= hit ? 20'd0 : window_nxt;
    end
  end

  // Symbol assembly and nibble phase. Held clear outside DATA.
  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      sym_sh  <= 5'd0;
      bit_cnt <= 3'd0;
      nib_odd <= 1'b0;
      low_nib <= 4'd0;
    end else if (!rx_en || (state == ST_IDLE)) begin
      sym_sh  <= 5'd0;
      bit_cnt <= 3'd0;
      nib_odd <= 1'b0;
    end else if (rx_bit_vld) begin
      sym_sh <= sym_nxt;
      if (bit_cnt == 3'd4) begin
        bit_cnt <= 3'd0;
        if (dec_valid) begin
          if (!nib_odd) low_nib <= dec_nib;
          nib_odd <= ~nib_odd;
        end
      end else begin
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // CRC register and payload counter. Both restart on SOP.
  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      crc      <= CRC_INIT;
      rx_paysz <= '0;
    end else if (sop_go) begin
      crc      <= CRC_INIT;
      rx_paysz <= '0;
    end else if (byte_done) begin
      crc <= crc_byte(crc, new_byte);
      if (rx_paysz != PAYSZ_MAX) rx_paysz <= rx_paysz + 1'b1;
    end
  end

  // Last detected ordered-set index.
  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n)                       rx_ordset_type <= 3'd0;
    else if (sop_go || hrst_go || crst_go) rx_ordset_type <= hit_idx;
  end

  // RXDR holding register. A byte arriving while the old one is unread is dropped.
  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      rx_rxdr <= 8'd0;
      rx_ne   <= 1'b0;
      rx_ovr  <= 1'b0;
    end else begin
      rx_ovr <= 1'b0;
      if (byte_done) begin
        if (rx_ne && !rxdr_rd) begin
          rx_ovr <= 1'b1;
        end else begin
          rx_rxdr <= new_byte;
          rx_ne   <= 1'b1;
        end
      end else if (rxdr_rd) begin
        rx_ne <= 1'b0;
      end
    end
  end

  // One-cycle status pulses.
  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      rx_sop_det  <= 1'b0;
      rx_hrst_det <= 1'b0;
      rx_crst_det <= 1'b0;
      rx_msg_end  <= 1'b0;
      rx_err      <= 1'b0;
    end else begin
      rx_sop_det  <= sop_go;
      rx_hrst_det <= hrst_go;
      rx_crst_det <= crst_go;
      rx_msg_end  <= msg_end_go;
      rx_err      <= err_go;
    end
  end

endmodule

// File: tb/tb_apb_ucpd_data_rx.sv
// Directed bench for the UCPD receive data path.
module tb_apb_ucpd_data_rx;

  logic       ic_clk;
  logic       ic_rst_n;
  logic       rx_en;
  logic       rx_bit;
  logic       rx_bit_vld;
  logic [6:0] rx_ordset_en;
  logic       rxdr_rd;
  logic [7:0] rx_rxdr;
  logic       rx_ne;
  logic [2:0] rx_ordset_type;
  logic [9:0] rx_paysz;
  logic       rx_sop_det, rx_hrst_det, rx_crst_det, rx_ovr, rx_msg_end, rx_err, rx_busy;

  int checks = 0;
  int errors = 0;
  int n_sop = 0, n_hrst = 0, n_crst = 0, n_ovr = 0, n_end = 0, n_err = 0;

  // 4b5b encode table, bit0 is sent first.
  logic [4:0] enc [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101,
                           5'b01010, 5'b01011, 5'b01110, 5'b01111,
                           5'b10010, 5'b10011, 5'b10110, 5'b10111,
                           5'b11010, 5'b11011, 5'b11100, 5'b11101};
  localparam logic [4:0] S1 = 5'b11000, S2 = 5'b10001, S3 = 5'b00110;
  localparam logic [4:0] R1 = 5'b00111, R2 = 5'b11001, EOPS = 5'b01101;
  logic [7:0] msg [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                           8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};

  apb_ucpd_data_rx #(.PAYSZ_W(10)) dut (
    .ic_clk(ic_clk), .ic_rst_n(ic_rst_n), .rx_en(rx_en), .rx_bit(rx_bit),
    .rx_bit_vld(rx_bit_vld), .rx_ordset_en(rx_ordset_en), .rxdr_rd(rxdr_rd),
    .rx_rxdr(rx_rxdr), .rx_ne(rx_ne), .rx_ordset_type(rx_ordset_type),
    .rx_paysz(rx_paysz), .rx_sop_det(rx_sop_det), .rx_hrst_det(rx_hrst_det),
    .rx_crst_det(rx_crst_det), .rx_ovr(rx_ovr), .rx_msg_end(rx_msg_end),
    .rx_err(rx_err), .rx_busy(rx_busy)
  );

  // Clock
  initial ic_clk = 1'b0;
  always #5 ic_clk = ~ic_clk;

  // Pulse monitors
  always @(negedge ic_clk) begin
    if (rx_sop_det)  n_sop++;
    if (rx_hrst_det) n_hrst++;
    if (rx_crst_det) n_crst++;
    if (rx_ovr)      n_ovr++;
    if (rx_msg_end)  n_end++;
    if (rx_msg_end && rx_err) n_err++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ic_clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic rd);
    rx_bit = b; rx_bit_vld = 1'b1; rxdr_rd = rd;
    tick();
    rx_bit_vld = 1'b0; rxdr_rd = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_sym(input logic [4:0] s, input logic rd_last);
    for (int i = 0; i < 5; i++) send_bit(s[i], rd_last && (i == 4));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rd_last);
    send_sym(enc[b[3:0]], 1'b0);
    send_sym(enc[b[7:4]], rd_last);
  endtask

  task automatic rd_pulse();
    rxdr_rd = 1'b1;
    tick();
    rxdr_rd = 1'b0;
  endtask

  task automatic send_set(input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] c, input logic [4:0] d);
    for (int i = 0; i < 64; i++) send_bit((i % 2) == 0, 1'b0);
    send_sym(a, 1'b0); send_sym(b, 1'b0); send_sym(c, 1'b0); send_sym(d, 1'b0);
  endtask

  // Full "123456789"+CRC message; last byte may be altered to corrupt the CRC.
  task automatic send_msg(input logic [7:0] last, input logic chk);
    logic [7:0] b;
    send_set(S1, S1, S1, S2);
    for (int i = 0; i < 13; i++) begin
      b = (i == 12) ? last : msg[i];
      send_byte(b, 1'b0);
      if (chk) check_eq("rxdr_byte", {24'd0, rx_rxdr}, {24'd0, b});
      rd_pulse();
    end
    send_sym(EOPS, 1'b0);
  endtask

  int s0, e0, r0, o0, h0, c0;

  initial begin
    ic_rst_n = 1'b0; rx_en = 1'b0; rx_bit = 1'b0; rx_bit_vld = 1'b0;
    rx_ordset_en = 7'h00; rxdr_rd = 1'b0;
    tick(); tick(); tick();
    ic_rst_n = 1'b1;
    tick();
    check_eq("rst_rxdr", {24'd0, rx_rxdr}, 32'h0);
    check_eq("rst_ne", {31'd0, rx_ne}, 32'h0);
    check_eq("rst_paysz", {22'd0, rx_paysz}, 32'h0);
    check_eq("rst_busy", {31'd0, rx_busy}, 32'h0);
    check_eq("rst_type", {29'd0, rx_ordset_type}, 32'h0);

    // SOP detection
    rx_en = 1'b1; rx_ordset_en = 7'h01;
    send_set(S1, S1, S1, S2);
    check_eq("sop_cnt", n_sop, 1);
    check_eq("sop_type", {29'd0, rx_ordset_type}, 32'd0);
    check_eq("sop_busy", {31'd0, rx_busy}, 32'd1);
    // Finish this message by an invalid-symbol abort so the next test starts clean
    send_sym(S2, 1'b0);

    // Good CRC message
    e0 = n_end; r0 = n_err;
    send_msg(8'hCB, 1'b1);
    check_eq("msg_end", n_end - e0, 1);
    check_eq("msg_err", n_err - r0, 0);
    check_eq("msg_paysz", {22'd0, rx_paysz}, 32'd13);
    check_eq("msg_busy", {31'd0, rx_busy}, 32'd0);

    // Corrupted CRC
    e0 = n_end; r0 = n_err;
    send_msg(8'hCA, 1'b0);
    check_eq("crc_bad_end", n_end - e0, 1);
    check_eq("crc_bad_err", n_err - r0, 1);

    // Hard reset with one corrupted symbol
    rx_ordset_en = 7'h08; h0 = n_hrst; s0 = n_sop;
    send_set(R1, R1, R2, R2);
    check_eq("hrst_cnt", n_hrst - h0, 1);
    check_eq("hrst_type", {29'd0, rx_ordset_type}, 32'd3);
    check_eq("hrst_busy", {31'd0, rx_busy}, 32'd0);
    rx_ordset_en = 7'h00; h0 = n_hrst;
    send_set(R1, R1, R2, R2);
    check_eq("hrst_dis", n_hrst - h0, 0);
    check_eq("hrst_nosop", n_sop - s0, 0);

    // Cable reset
    rx_ordset_en = 7'h10; c0 = n_crst;
    send_set(R1, S1, R1, S3);
    check_eq("crst_cnt", n_crst - c0, 1);
    check_eq("crst_type", {29'd0, rx_ordset_type}, 32'd4);

    // Overrun
    rx_ordset_en = 7'h01; o0 = n_ovr;
    send_set(S1, S1, S1, S2);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b0);
    check_eq("ovr_keep", {24'd0, rx_rxdr}, 32'hA5);
    check_eq("ovr_cnt", n_ovr - o0, 1);
    check_eq("ovr_paysz", {22'd0, rx_paysz}, 32'd2);
    send_byte(8'h7E, 1'b1);
    check_eq("rdload_rxdr", {24'd0, rx_rxdr}, 32'h7E);
    check_eq("rdload_ne", {31'd0, rx_ne}, 32'd1);
    check_eq("rdload_noovr", n_ovr - o0, 1);
    send_sym(EOPS, 1'b0);
    rd_pulse();
    check_eq("rd_clear_ne", {31'd0, rx_ne}, 32'd0);

    // Invalid symbol mid-message
    e0 = n_end; r0 = n_err;
    send_set(S1, S1, S1, S2);
    send_sym(enc[4], 1'b0);
    send_sym(S2, 1'b0);
    check_eq("badsym_end", n_end - e0, 1);
    check_eq("badsym_err", n_err - r0, 1);
    check_eq("badsym_busy", {31'd0, rx_busy}, 32'd0);

    // Odd nibble count before EOP
    e0 = n_end; r0 = n_err;
    send_set(S1, S1, S1, S2);
    send_sym(enc[5], 1'b0);
    send_sym(EOPS, 1'b0);
    check_eq("odd_end", n_end - e0, 1);
    check_eq("odd_err", n_err - r0, 1);

    // Disable mid-DATA
    e0 = n_end; s0 = n_sop;
    send_set(S1, S1, S1, S2);
    send_byte(8'h55, 1'b0);
    rx_en = 1'b0;
    tick();
    check_eq("dis_busy", {31'd0, rx_busy}, 32'd0);
    send_sym(S1, 1'b0);
    send_sym(S1, 1'b0);
    check_eq("dis_noend", n_end - e0, 0);
    check_eq("dis_ne_keep", {31'd0, rx_ne}, 32'd1);
    check_eq("dis_rxdr_keep", {24'd0, rx_rxdr}, 32'h55);
    check_eq("dis_sop", n_sop - s0, 1);

    // Reset mid-message
    rx_en = 1'b1; rd_pulse();
    send_set(S1, S1, S1, S2);
    send_byte(8'h99, 1'b0);
    check_eq("pre_rst_busy", {31'd0, rx_busy}, 32'd1);
    ic_rst_n = 1'b0;
    #2;
    check_eq("mrst_rxdr", {24'd0, rx_rxdr}, 32'h0);
    check_eq("mrst_ne", {31'd0, rx_ne}, 32'h0);
    check_eq("mrst_paysz", {22'd0, rx_paysz}, 32'h0);
    check_eq("mrst_busy", {31'd0, rx_busy}, 32'h0);
    check_eq("mrst_end", {31'd0, rx_msg_end}, 32'h0);
    tick();
    ic_rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
